lab3_burst_checker: RTL and testbench

- Sits directly downstream of the LAB3 read/sum stage and consumes its output stream.
- The upstream burst format is:
  - OUT_VALID is high for N+1 consecutive cycles.
  - The first N beats are 3-bit data words, zero-extended to 6 bits.
  - The last beat is the 6-bit sum of those data words.
- This block re-accumulates the data words, identifies the trailer when valid falls, and checks the trailer against its own sum.
- It reports pass/fail plus count, max and min of the data words as a one-cycle result pulse.

---
 rtl/lab3_burst_checker_if.sv | 24 ++
 rtl/lab3_burst_checker.sv | 107 ++++++++++
 tb/tb_lab3_burst_checker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lab3_burst_checker_if.sv
// Burst stream in, result report out, between the LAB3 read/sum stage and the checker.
interface lab3_burst_checker_if #(
   parameter int DW = 6,
   parameter int VW = 3
);
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          o_valid;
   logic          o_pass;
   logic [3:0]    o_count;
   logic [VW-1:0] o_max_w;
   logic [VW-1:0] o_min_w;
   logic [1:0]    o_err;

   modport master (
      output i_valid, i_data,
      input  o_valid, o_pass, o_count, o_max_w, o_min_w, o_err
   );

   modport slave (
      input  i_valid, i_data,
      output o_valid, o_pass, o_count, o_max_w, o_min_w, o_err
   );
endinterface

// File: rtl/lab3_burst_checker.sv
// Re-sums each upstream burst, checks its trailer word and reports
// pass/fail with count, max and min of the data words as a one-cycle strobe.
module lab3_burst_checker #(
   parameter int DW        = 6,
   parameter int VW        = 3,
   parameter int MAX_WORDS = 7,
   parameter int SW        = 8
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   lab3_burst_checker_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RECV   = 2'd1;
   localparam logic [1:0] S_REPORT = 2'd2;

   logic [1:0]    r_state;
   logic [DW-1:0] r_hold;
   logic [SW-1:0] r_sum;
   logic [3:0]    r_cnt;
   logic [VW-1:0] r_max;
   logic [VW-1:0] r_min;
   logic          r_range;

   logic          r_valid;
   logic          r_pass;
   logic [3:0]    r_count;
   logic [VW-1:0] r_max_w;
   logic [VW-1:0] r_min_w;
   logic [1:0]    r_err;

   logic [VW-1:0] w_held_lo;
   logic          w_held_hi;
   logic [SW-1:0] w_held_ext;
   logic [3:0]    w_cnt_inc;
   logic          w_overflow;
   logic          w_empty;

   // The word in r_hold is only known to be data once another beat follows it.
   assign w_held_lo  = r_hold[VW-1:0];
   assign w_held_hi  = |r_hold[DW-1:VW];
   assign w_held_ext = SW'(r_hold);
   assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
   assign w_overflow = (r_cnt > 4'(MAX_WORDS));
   assign w_empty    = (r_cnt == 4'd0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_max   <= '0;
         r_min   <= '0;
         r_range <= 1'b0;
         r_valid <= 1'b0;
         r_pass  <= 1'b0;
         r_count <= '0;
         r_max_w <= '0;
         r_min_w <= '0;
         r_err   <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_REPORT: begin
               if (bus.i_valid) begin
                  r_hold  <= bus.i_data;
                  r_sum   <= '0;
                  r_cnt   <= '0;
                  r_max   <= '0;
                  r_min   <= '1;
                  r_range <= 1'b0;
                  r_state <= S_RECV;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RECV: begin
               if (bus.i_valid) begin
                  r_sum <= r_sum + w_held_ext;
                  r_cnt <= w_cnt_inc;
                  if (w_held_lo > r_max) r_max <= w_held_lo;
                  if (w_held_lo < r_min) r_min <= w_held_lo;
                  if (w_held_hi) r_range <= 1'b1;
                  r_hold <= bus.i_data;
               end else begin
                  r_valid <= 1'b1;
                  r_pass  <= (w_held_ext == r_sum) && !r_range && !w_overflow;
                  r_count <= r_cnt;
                  r_max_w <= w_empty ? '0 : r_max;
                  r_min_w <= w_empty ? '0 : r_min;
                  r_err   <= {w_overflow, r_range};
                  r_state <= S_REPORT;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_valid = r_valid;
   assign bus.o_pass  = r_pass;
   assign bus.o_count = r_count;
   assign bus.o_max_w = r_max_w;
   assign bus.o_min_w = r_min_w;
   assign bus.o_err   = r_err;
endmodule

// File: tb/tb_lab3_burst_checker.sv
// Directed bench for lab3_burst_checker: hand-computed bursts, back-to-back reports and mid-burst reset.
module tb_lab3_burst_checker;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   lab3_burst_checker_if #(.DW(6), .VW(3)) bus ();

   lab3_burst_checker #(.DW(6), .VW(3), .MAX_WORDS(7), .SW(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge so the design samples them cleanly at the next rising edge.
   task automatic applyStimulus(input logic v, input logic [5:0] d);
      @(negedge clk);
      bus.i_valid = v;
      bus.i_data  = d;
   endtask

   task automatic checkOutput(input string tag, input logic v, input logic p, input logic [3:0] c,
                              input logic [2:0] mx, input logic [2:0] mn, input logic [1:0] e);
      check({tag, ".valid"}, 8'(bus.o_valid), 8'(v));
      check({tag, ".pass"},  8'(bus.o_pass),  8'(p));
      check({tag, ".count"}, 8'(bus.o_count), 8'(c));
      check({tag, ".max"},   8'(bus.o_max_w), 8'(mx));
      check({tag, ".min"},   8'(bus.o_min_w), 8'(mn));
      check({tag, ".err"},   8'(bus.o_err),   8'(e));
   endtask

   // Sends data words then the trailer, drops valid, and lands on the strobe cycle (trailer + 2).
   task automatic sendBurst(input logic [5:0] words[$], input logic [5:0] trailer);
      foreach (words[i]) applyStimulus(1'b1, words[i]);
      applyStimulus(1'b1, trailer);
      applyStimulus(1'b0, 6'd0);
      check("pre_strobe.valid", 8'(bus.o_valid), 8'd0);
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] w[$];
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      #2;
      checkOutput("reset", 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      w = '{6'd3, 6'd5, 6'd1};
      sendBurst(w, 6'd9);
      checkOutput("b351_9", 1'b1, 1'b1, 4'd3, 3'd5, 3'd1, 2'd0);
      @(negedge clk);
      checkOutput("b351_9_hold", 1'b0, 1'b1, 4'd3, 3'd5, 3'd1, 2'd0);

      sendBurst(w, 6'd8);
      checkOutput("b351_8", 1'b1, 1'b0, 4'd3, 3'd5, 3'd1, 2'd0);

      w = '{};
      sendBurst(w, 6'd0);
      checkOutput("single0", 1'b1, 1'b1, 4'd0, 3'd0, 3'd0, 2'd0);
      sendBurst(w, 6'd4);
      checkOutput("single4", 1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 2'd0);

      w = '{6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7};
      sendBurst(w, 6'd56);
      checkOutput("eight7", 1'b1, 1'b0, 4'd8, 3'd7, 3'd7, 2'b10);
      w = '{6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7};
      sendBurst(w, 6'd49);
      checkOutput("seven7", 1'b1, 1'b1, 4'd7, 3'd7, 3'd7, 2'b00);

      w = '{6'd2, 6'd9};
      sendBurst(w, 6'd11);
      check("range.valid", 8'(bus.o_valid), 8'd1);
      check("range.pass",  8'(bus.o_pass),  8'd0);
      check("range.count", 8'(bus.o_count), 8'd2);
      check("range.err",   8'(bus.o_err),   8'd1);

      // Burst B's first beat arrives in the same cycle as burst A's strobe.
      w = '{6'd1, 6'd1};
      sendBurst(w, 6'd2);
      checkOutput("btbA", 1'b1, 1'b1, 4'd2, 3'd1, 3'd1, 2'd0);
      bus.i_valid = 1'b1;
      bus.i_data  = 6'd6;
      applyStimulus(1'b1, 6'd6);
      applyStimulus(1'b0, 6'd0);
      check("btbB_pre.valid", 8'(bus.o_valid), 8'd0);
      @(negedge clk);
      checkOutput("btbB", 1'b1, 1'b1, 4'd1, 3'd6, 3'd6, 2'd0);

      applyStimulus(1'b1, 6'd3);
      applyStimulus(1'b1, 6'd4);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 2'd0);
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_strobe_after_reset", 8'(bus.o_valid), 8'd0);
      end

      w = '{6'd2, 6'd3};
      sendBurst(w, 6'd5);
      checkOutput("post_reset", 1'b1, 1'b1, 4'd2, 3'd3, 3'd2, 2'd0);
      @(negedge clk);
      check("post_reset_drop.valid", 8'(bus.o_valid), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
